// File: rtl/cdc_handshake_source_pkg.sv
// Shared types and default sizes for the toggle-handshake CDC source.
package cdc_handshake_source_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_SYNC_DEPTH = 3;
    localparam int DEFAULT_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        WAIT   = 2'd2
    } state_e;

endpackage

// File: rtl/cdc_sync_bit.sv
// Plain flop-chain synchronizer for a single asynchronous bit; deliberately unreset
// so the chain flushes naturally after reset.
module cdc_sync_bit #(
    parameter int DEPTH = 3
) (
    input  logic clock,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_q;

    always_ff @(posedge clock) begin
        sync_q <= {sync_q[DEPTH-2:0], d};
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_source.sv
// Transmit side of a 2-phase req/ack CDC. Optional one-entry skid buffer is
// enabled by defining CDC_HANDSHAKE_SOURCE_SKID_EN.
module cdc_handshake_source
    import cdc_handshake_source_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SYNC_DEPTH = DEFAULT_SYNC_DEPTH,
    parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 io_enq_valid,
    output logic                 io_enq_ready,
    input  logic [WIDTH-1:0]     io_enq_bits,
    output logic                 io_async_req,
    output logic [WIDTH-1:0]     io_async_data,
    input  logic                 io_async_ack,
    output logic                 io_idle,
    output logic [CNT_WIDTH-1:0] io_sent_count,
    output state_e               dbg_state
);

    localparam int FLUSH_W = $clog2(SYNC_DEPTH + 1);

    state_e               state_q, state_d;
    logic                 req_q;
    logic [WIDTH-1:0]     data_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic [FLUSH_W-1:0]   flush_cnt_q;
    logic                 ack_sync;
    logic                 flush_done;
    logic                 ack_seen;
    logic                 fire;
`ifdef CDC_HANDSHAKE_SOURCE_SKID_EN
    logic [WIDTH-1:0]     skid_q;
    logic                 skid_valid_q;
`endif

    cdc_sync_bit #(.DEPTH(SYNC_DEPTH)) u_ack_sync (
        .clock (clock),
        .d     (io_async_ack),
        .q     (ack_sync)
    );

    // Enqueue handshake: a word transfers on any clock edge where io_enq_valid and
    // io_enq_ready are both high; ready never depends on valid.
    assign fire       = io_enq_valid && io_enq_ready;
    assign flush_done = (flush_cnt_q == FLUSH_W'(SYNC_DEPTH));
    assign ack_seen   = (state_q == WAIT) && (ack_sync == req_q);

    always_ff @(posedge clock) begin
        if (!reset) state_q <= RESYNC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESYNC: if (flush_done && (ack_sync == req_q)) state_d = IDLE;
            IDLE:   if (fire) state_d = WAIT;
            WAIT: begin
`ifdef CDC_HANDSHAKE_SOURCE_SKID_EN
                if (ack_seen && !skid_valid_q && !fire) state_d = IDLE;
`else
                if (ack_seen) state_d = IDLE;
`endif
            end
            default: state_d = RESYNC;
        endcase
    end

    always_comb begin
        io_enq_ready = 1'b0;
        io_idle      = 1'b0;
        case (state_q)
            IDLE: begin
                io_enq_ready = 1'b1;
                io_idle      = 1'b1;
            end
`ifdef CDC_HANDSHAKE_SOURCE_SKID_EN
            WAIT: io_enq_ready = !skid_valid_q;
`endif
            default: ;
        endcase
    end

    // Data and req always move on the same edge; the sink's synchronizer on req
    // gives data time to settle before the toggle is seen.
    always_ff @(posedge clock) begin
        if (!reset) begin
            req_q       <= 1'b0;
            data_q      <= '0;
            count_q     <= '0;
            flush_cnt_q <= '0;
`ifdef CDC_HANDSHAKE_SOURCE_SKID_EN
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
`endif
        end else begin
            if ((state_q == RESYNC) && !flush_done) flush_cnt_q <= flush_cnt_q + 1'b1;
            if (ack_seen) count_q <= count_q + 1'b1;
            if ((state_q == IDLE) && fire) begin
                data_q <= io_enq_bits;
                req_q  <= ~req_q;
            end
`ifdef CDC_HANDSHAKE_SOURCE_SKID_EN
            if (state_q == WAIT) begin
                if (ack_seen) begin
                    if (skid_valid_q) begin
                        data_q       <= skid_q;
                        req_q        <= ~req_q;
                        skid_valid_q <= 1'b0;
                    end else if (fire) begin
                        data_q <= io_enq_bits;
                        req_q  <= ~req_q;
                    end
                end else if (fire) begin
                    skid_q       <= io_enq_bits;
                    skid_valid_q <= 1'b1;
                end
            end
`endif
        end
    end

    assign io_async_req  = req_q;
    assign io_async_data = data_q;
    assign io_sent_count = count_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_cdc_handshake_source.sv
// Bench for cdc_handshake_source: sink-side scoreboard on req toggles, directed
// sequences for reset/latency/backpressure, and a table of transfers wrapping a 4-bit count.
module tb_cdc_handshake_source;
    import cdc_handshake_source_pkg::*;

    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          io_enq_valid;
    logic          io_enq_ready;
    logic [W-1:0]  io_enq_bits;
    logic          io_async_req;
    logic [W-1:0]  io_async_data;
    logic          io_async_ack;
    logic          io_idle;
    logic [CW-1:0] io_sent_count;
    state_e        dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0]  bits;
        int unsigned   delay;
        logic [CW-1:0] exp_count;
    } vec_t;
    vec_t vecs[16];

    cdc_handshake_source #(.WIDTH(W), .SYNC_DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_enq_valid  (io_enq_valid),
        .io_enq_ready  (io_enq_ready),
        .io_enq_bits   (io_enq_bits),
        .io_async_req  (io_async_req),
        .io_async_data (io_async_data),
        .io_async_ack  (io_async_ack),
        .io_idle       (io_idle),
        .io_sent_count (io_sent_count),
        .dbg_state     (dbg_state)
    );

    // Clock and watchdog
    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Driver: present a word, wait for ready, log the expected word, take the edge.
    task automatic enq(input logic [W-1:0] b);
        int n = 0;
        io_enq_valid = 1'b1;
        io_enq_bits  = b;
        while (!io_enq_ready && n < 50) begin
            tick();
            n++;
        end
        check("enq_ready", io_enq_ready, 1);
        if (io_enq_ready) begin
            exp_q.push_back(b);
            tick();
        end
        io_enq_valid = 1'b0;
    endtask

    // Sink returns the ack toggle, then the recognition latency is checked.
    task automatic complete_ack(input logic [CW-1:0] exp_count);
        io_async_ack = io_async_req;
        for (int i = 0; i < D; i++) begin
            tick();
            check("ready_before_ack_sync", io_enq_ready, 0);
        end
        tick();
        check("ready_after_ack", io_enq_ready, 1);
        check("idle_after_ack", io_idle, 1);
        check("sent_count", io_sent_count, exp_count);
    endtask

    // Scoreboard: each req toggle must carry the next expected word; data is
    // otherwise stable.
    logic         last_req  = 1'b0;
    logic [W-1:0] last_data = '0;
    always @(posedge clock) begin
        #1;
        if (!reset) begin
            last_req  = 1'b0;
            last_data = '0;
        end else if (io_async_req != last_req) begin
            last_req = io_async_req;
            if (exp_q.size() == 0) begin
                check("unexpected_req_toggle", 1, 0);
            end else begin
                check("sink_data", io_async_data, exp_q.pop_front());
            end
            last_data = io_async_data;
        end else begin
            check("data_stable", io_async_data, last_data);
        end
    end

    initial begin
        reset        = 1'b0;
        io_enq_valid = 1'b0;
        io_enq_bits  = '0;
        io_async_ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vecs[i].bits      = W'($urandom_range(0, 255));
            vecs[i].delay     = $urandom_range(0, 4);
            vecs[i].exp_count = CW'((i + 1) % 16);
        end

        // Reset and resync window
        @(negedge clock);
        tick();
        tick();
        check("rst_req", io_async_req, 0);
        check("rst_data", io_async_data, 0);
        check("rst_count", io_sent_count, 0);
        check("rst_ready", io_enq_ready, 0);
        check("rst_idle", io_idle, 0);
        check("rst_state", dbg_state, RESYNC);
        reset = 1'b1;
        for (int i = 0; i < D; i++) begin
            tick();
            check("resync_ready", io_enq_ready, 0);
        end
        tick();
        check("resync_done_ready", io_enq_ready, 1);
        check("resync_done_state", dbg_state, IDLE);

        // First transfer and ack latency
        enq(8'hA5);
        check("t2_req", io_async_req, 1);
        check("t2_data", io_async_data, 8'hA5);
        check("t2_idle", io_idle, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_wait_ready", io_enq_ready, 0);
            check("t2_wait_data", io_async_data, 8'hA5);
        end
        complete_ack(CW'(1));

`ifndef CDC_HANDSHAKE_SOURCE_SKID_EN
        // Backpressure while pending
        enq(8'h5A);
        io_enq_valid = 1'b1;
        io_enq_bits  = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_hold_data", io_async_data, 8'h5A);
            check("t3_hold_ready", io_enq_ready, 0);
        end
        io_async_ack = io_async_req;
        for (int i = 0; i < D; i++) begin
            tick();
            check("t3_pending_data", io_async_data, 8'h5A);
        end
        tick();
        check("t3_ready", io_enq_ready, 1);
        check("t3_count", io_sent_count, 2);
        exp_q.push_back(8'h3C);
        tick();
        io_enq_valid = 1'b0;
        check("t3_req", io_async_req, 1);
        check("t3_data", io_async_data, 8'h3C);
        complete_ack(CW'(3));
`endif

        // Reset mid-transfer with ack stuck high
        enq(8'hE1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("t5_req", io_async_req, 0);
        check("t5_data", io_async_data, 0);
        check("t5_count", io_sent_count, 0);
        check("t5_ready", io_enq_ready, 0);
        reset        = 1'b1;
        io_async_ack = 1'b1;
        for (int i = 0; i < D + 4; i++) begin
            tick();
            check("t5_stale_ready", io_enq_ready, 0);
            check("t5_stale_state", dbg_state, RESYNC);
        end
        io_async_ack = 1'b0;
        for (int i = 0; i < D; i++) begin
            tick();
            check("t5_flush_ready", io_enq_ready, 0);
        end
        tick();
        check("t5_ready_back", io_enq_ready, 1);

        // Table of transfers; the 16th wraps the 4-bit count to zero
        for (int i = 0; i < 16; i++) begin
            enq(vecs[i].bits);
            check("tbl_data", io_async_data, vecs[i].bits);
            repeat (vecs[i].delay) tick();
            complete_ack(vecs[i].exp_count);
        end

        // Spurious ack toggles in IDLE are not counted
        io_async_ack = ~io_async_ack;
        repeat (D + 3) tick();
        check("spur_count", io_sent_count, 0);
        check("spur_state", dbg_state, IDLE);
        io_async_ack = ~io_async_ack;
        repeat (D + 3) tick();
        check("spur_count2", io_sent_count, 0);
        check("spur_ready", io_enq_ready, 1);

`ifdef CDC_HANDSHAKE_SOURCE_SKID_EN
        // Back-to-back words through the skid entry
        enq(8'h11);
        enq(8'h22);
        check("t4_skid_full_ready", io_enq_ready, 0);
        check("t4_data1", io_async_data, 8'h11);
        io_async_ack = io_async_req;
        for (int i = 0; i < D; i++) begin
            tick();
            check("t4_data1_hold", io_async_data, 8'h11);
        end
        tick();
        check("t4_data2", io_async_data, 8'h22);
        check("t4_count1", io_sent_count, 1);
        check("t4_state", dbg_state, WAIT);
        complete_ack(CW'(2));
`endif

        repeat (4) tick();
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
